// File: rtl/mem_arbiter_if.sv
// Arbiter bundle: fetch port, data port and memory-side signals.
// slave = arbiter side, master = core/memory side.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_valid;
  logic [31:0] if_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_valid;
  logic [31:0] mem_rdata;

  logic        m_en;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        sel;
  logic        stall;

  modport slave (
    input  if_req, if_addr,
    input  mem_req, mem_we,
    input  mem_addr, mem_wdata,
    input  m_rdata,
    output if_gnt, if_valid, if_rdata,
    output mem_gnt, mem_valid, mem_rdata,
    output m_en, m_we, m_addr, m_wdata,
    output sel, stall
  );

  modport master (
    output if_req, if_addr,
    output mem_req, mem_we,
    output mem_addr, mem_wdata,
    output m_rdata,
    input  if_gnt, if_valid, if_rdata,
    input  mem_gnt, mem_valid, mem_rdata,
    input  m_en, m_we, m_addr, m_wdata,
    input  sel, stall
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data single-memory arbiter with fixed access latency.
// Define MEM_ARB_RR_EN for round-robin instead of data priority.
module mem_arbiter #(
  parameter int unsigned LATENCY = 2
) (
  input  logic     clk,
  input  logic     rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_MEM
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       pick_mem;

`ifdef MEM_ARB_RR_EN
  logic last_mem;

  // On a tie, serve the port that was not served last.
  always_comb
    pick_mem = bus.mem_req &
               (~bus.if_req | ~last_mem);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      last_mem <= 1'b0;
    else if (state == IDLE &&
             (bus.mem_req || bus.if_req))
      last_mem <= pick_mem;
  end
`else
  always_comb pick_mem = bus.mem_req;
`endif

  assign bus.stall = rst & (
    (bus.if_req  & ~bus.if_valid) |
    (bus.mem_req & ~bus.mem_valid));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.if_gnt    <= 1'b0;
      bus.if_valid  <= 1'b0;
      bus.if_rdata  <= '0;
      bus.mem_gnt   <= 1'b0;
      bus.mem_valid <= 1'b0;
      bus.mem_rdata <= '0;
      bus.m_en      <= 1'b0;
      bus.m_we      <= 1'b0;
      bus.m_addr    <= '0;
      bus.m_wdata   <= '0;
      bus.sel       <= 1'b0;
    end else begin
      bus.if_gnt    <= 1'b0;
      bus.mem_gnt   <= 1'b0;
      bus.if_valid  <= 1'b0;
      bus.mem_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_mem) begin
            state       <= BUSY_MEM;
            cnt         <= CNT_INIT;
            bus.mem_gnt <= 1'b1;
            bus.m_en    <= 1'b1;
            bus.m_we    <= bus.mem_we;
            bus.m_addr  <= bus.mem_addr;
            bus.m_wdata <= bus.mem_wdata;
            bus.sel     <= 1'b1;
          end else if (bus.if_req) begin
            state      <= BUSY_IF;
            cnt        <= CNT_INIT;
            bus.if_gnt <= 1'b1;
            bus.m_en   <= 1'b1;
            bus.m_we   <= 1'b0;
            bus.m_addr <= bus.if_addr;
            bus.sel    <= 1'b0;
          end
        end
        BUSY_IF, BUSY_MEM: begin
          if (cnt == 4'd0) begin
            state    <= IDLE;
            bus.m_en <= 1'b0;
            bus.m_we <= 1'b0;
            bus.sel  <= 1'b0;
            if (state == BUSY_MEM) begin
              bus.mem_valid <= 1'b1;
              bus.mem_rdata <= bus.m_rdata;
            end else begin
              bus.if_valid <= 1'b1;
              bus.if_rdata <= bus.m_rdata;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (LATENCY=2 and LATENCY=1).
// Expected grant order follows MEM_ARB_RR_EN when defined.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   fails;
  logic exp_mem;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if b0 ();
  mem_arbiter_if b1 ();

  mem_arbiter #(.LATENCY(2)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  mem_arbiter #(.LATENCY(1)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    fails = 0;
    rst = 1'b0;
    b0.if_req = 1'b0;
    b0.if_addr = '0;
    b0.mem_req = 1'b0;
    b0.mem_we = 1'b0;
    b0.mem_addr = '0;
    b0.mem_wdata = '0;
    b0.m_rdata = '0;
    b1.if_req = 1'b0;
    b1.if_addr = '0;
    b1.mem_req = 1'b0;
    b1.mem_we = 1'b0;
    b1.mem_addr = '0;
    b1.mem_wdata = '0;
    b1.m_rdata = '0;
    step;
    step;

    // reset state
    chk("rst_gnt", {b0.if_gnt, b0.mem_gnt}, 0);
    chk("rst_vld", {b0.if_valid, b0.mem_valid}, 0);
    chk("rst_en", {b0.m_en, b0.m_we, b0.sel}, 0);
    chk("rst_stall", b0.stall, 0);
    chk("rst_addr", b0.m_addr, 0);
    chk("rst_wdata", b0.m_wdata, 0);
    chk("rst_ifrd", b0.if_rdata, 0);
    chk("rst_memrd", b0.mem_rdata, 0);
    rst = 1'b1;
    step;

    // fetch only
    b0.if_req = 1'b1;
    b0.if_addr = 32'h10;
    b0.m_rdata = 32'hDEADBEEF;
    step;
    chk("a_gnt", b0.if_gnt, 1);
    chk("a_sel", b0.sel, 0);
    chk("a_addr", b0.m_addr, 32'h10);
    chk("a_en", b0.m_en, 1);
    chk("a_stall", b0.stall, 1);
    b0.if_req = 1'b0;
    step;
    chk("a_gnt_pulse", b0.if_gnt, 0);
    chk("a_vld_early", b0.if_valid, 0);
    chk("a_en_busy", b0.m_en, 1);
    step;
    chk("a_vld", b0.if_valid, 1);
    chk("a_rdata", b0.if_rdata, 32'hDEADBEEF);
    chk("a_en_off", b0.m_en, 0);
    chk("a_addr_hold", b0.m_addr, 32'h10);
    step;
    chk("a_vld_pulse", b0.if_valid, 0);

    // simultaneous requests
    b0.if_req = 1'b1;
    b0.mem_req = 1'b1;
    b0.mem_we = 1'b0;
    b0.mem_addr = 32'h80;
    b0.m_rdata = 32'h11111111;
    step;
    chk("b_mgnt", b0.mem_gnt, 1);
    chk("b_ignt", b0.if_gnt, 0);
    chk("b_sel", b0.sel, 1);
    chk("b_addr", b0.m_addr, 32'h80);
    chk("b_we", b0.m_we, 0);
    b0.mem_req = 1'b0;
    b0.m_rdata = 32'h22222222;
    step;
    chk("b_stall1", b0.stall, 1);
    step;
    chk("b_mvld", b0.mem_valid, 1);
    chk("b_mrd", b0.mem_rdata, 32'h22222222);
    chk("b_stall2", b0.stall, 1);
    step;
    chk("b_ignt2", b0.if_gnt, 1);
    chk("b_sel2", b0.sel, 0);
    chk("b_addr2", b0.m_addr, 32'h10);
    b0.m_rdata = 32'h33333333;
    step;
    chk("b_stall3", b0.stall, 1);
    step;
    chk("b_ivld", b0.if_valid, 1);
    chk("b_ird", b0.if_rdata, 32'h33333333);
    chk("b_stall4", b0.stall, 0);
    b0.if_req = 1'b0;
    step;

    // back-to-back ties
    b0.if_req = 1'b1;
    b0.mem_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
      exp_mem = (k % 2 == 0);
`else
      exp_mem = 1'b1;
`endif
      step;
      chk("c_mgnt", b0.mem_gnt, exp_mem);
      chk("c_ignt", b0.if_gnt, !exp_mem);
      step;
      step;
      chk("c_vld", {b0.mem_valid, b0.if_valid},
          exp_mem ? 2'b10 : 2'b01);
    end
    b0.if_req = 1'b0;
    b0.mem_req = 1'b0;
    step;

    // write access
    b0.mem_req = 1'b1;
    b0.mem_we = 1'b1;
    b0.mem_addr = 32'h44;
    b0.mem_wdata = 32'h12345678;
    b0.m_rdata = 32'hCAFEF00D;
    step;
    chk("d_gnt", b0.mem_gnt, 1);
    chk("d_we", b0.m_we, 1);
    chk("d_addr", b0.m_addr, 32'h44);
    chk("d_wdata", b0.m_wdata, 32'h12345678);
    b0.mem_req = 1'b0;
    b0.mem_we = 1'b0;
    b0.mem_addr = '0;
    b0.mem_wdata = 32'hFFFFFFFF;
    step;
    chk("d_we2", b0.m_we, 1);
    chk("d_wdata2", b0.m_wdata, 32'h12345678);
    step;
    chk("d_vld", b0.mem_valid, 1);
    chk("d_rd", b0.mem_rdata, 32'hCAFEF00D);
    chk("d_we_off", b0.m_we, 0);
    step;
    chk("d_vld_pulse", b0.mem_valid, 0);
    chk("d_wdata_hold", b0.m_wdata, 32'h12345678);

    // reset mid-access
    b0.if_req = 1'b1;
    b0.if_addr = 32'h20;
    b0.m_rdata = 32'hBAD0BAD0;
    step;
    chk("e_gnt", b0.if_gnt, 1);
    step;
    chk("e_en", b0.m_en, 1);
    rst = 1'b0;
    #1;
    chk("e_en_off", b0.m_en, 0);
    chk("e_stall", b0.stall, 0);
    chk("e_addr", b0.m_addr, 0);
    chk("e_wdata", b0.m_wdata, 0);
    chk("e_rd", {b0.if_rdata | b0.mem_rdata}, 0);
    step;
    chk("e_novld", b0.if_valid, 0);
    chk("e_nognt", b0.if_gnt, 0);
    rst = 1'b1;
    step;
    chk("e_regnt", b0.if_gnt, 1);
    chk("e_readdr", b0.m_addr, 32'h20);
    step;
    step;
    chk("e_vld", b0.if_valid, 1);
    chk("e_ird", b0.if_rdata, 32'hBAD0BAD0);
    b0.if_req = 1'b0;
    step;

    // LATENCY=1 continuous fetch
    b1.if_req = 1'b1;
    b1.if_addr = 32'h100;
    b1.m_rdata = 32'h5A5A5A5A;
    for (int k = 0; k < 8; k++) begin
      step;
      chk("f_gnt", b1.if_gnt, (k % 2 == 0));
      chk("f_vld", b1.if_valid, (k % 2 == 1));
    end
    chk("f_rd", b1.if_rdata, 32'h5A5A5A5A);
    b1.if_req = 1'b0;
    step;

    $display("%0d/%0d checks passed",
             total - fails, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LATENCY, default 2, memory access latency in cycles, legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 if_req  input  1  fetch-port request (level).
REQ-005 if_addr  input  32  fetch address.
REQ-006 if_gnt  output  1  one-cycle pulse: fetch access accepted.
REQ-007 if_valid  output  1  one-cycle pulse: if_rdata valid.
REQ-008 if_rdata  output  32  fetched word.
REQ-009 mem_req  input  1  data-port request (level).
REQ-010 mem_we  input  1  data-port write enable.
REQ-011 mem_addr  input  32  data address.
REQ-012 mem_wdata  input  32  write data.
REQ-013 mem_gnt  output  1  one-cycle pulse: data access accepted.
REQ-014 mem_valid  output  1  one-cycle pulse: access complete, mem_rdata valid.
REQ-015 mem_rdata  output  32  read word.
REQ-016 m_en  output  1  memory enable.
REQ-017 m_we  output  1  memory write enable.
REQ-018 m_addr  output  32  memory address.
REQ-019 m_wdata  output  32  memory write data.
REQ-020 m_rdata  input  32  memory read data.
REQ-021 sel  output  1  select for the memory address mux (1 = data port, 0 = fetch port).
REQ-022 stall  output  1  pipeline stall request.

Function
REQ-023 FSM states IDLE, BUSY_IF, BUSY_MEM.
REQ-024 IDLE: on an edge with requests present, enter BUSY_MEM or BUSY_IF per the arbitration rule (REQ-031); latch addr/we/wdata; load counter with LATENCY-1; pulse the matching gnt in the following cycle.
REQ-025 BUSY_x: counter decrements each edge; on the edge where counter==0, capture m_rdata into x_rdata, assert x_valid for exactly one cycle, and return to IDLE.
REQ-026 Timing: with the request sampled at edge E0, valid is high in the cycle after edge E_LATENCY; throughput is one access per LATENCY+1 cycles.
REQ-027 m_en=1 in both BUSY states; m_addr/m_wdata are driven from the latched values; m_we = latched we AND BUSY_MEM; sel=1 only in BUSY_MEM.
REQ-028 In IDLE, m_en=0, m_we=0, and m_addr/m_wdata hold their last values.
REQ-029 No re-grant to a requester in the cycle its valid is high; this gives a one-cycle turnaround.
REQ-030 stall = (if_req AND NOT if_valid) OR (mem_req AND NOT mem_valid); stall is combinational.
REQ-031 Arbitration (default): data port has fixed priority over fetch.
REQ-032 Writes pulse mem_valid; mem_rdata captures m_rdata regardless of write.
REQ-033 Request inputs are ignored while BUSY; operand changes after the grant edge have no effect.

Reset
REQ-034 rst low: state=IDLE, counter=0, all outputs 0, rdata registers 0, latched operands 0, last-served=IF.
REQ-035 rst asserted mid-access aborts the access: no valid pulse, m_en drops immediately, and no grant occurs until after rst releases.

Configuration
REQ-036 Macro MEM_ARB_RR_EN defined: round-robin arbitration. Ties go to the port not last served; last-served updates on each grant and resets to IF, so the first tie goes to the data port.
REQ-037 Macro MEM_ARB_RR_EN undefined: fixed data priority; no last-served register is built.

Verification
REQ-038 LATENCY=2, fetch only: if_req=1, if_addr=0x10 at E0, m_rdata=0xDEADBEEF -> if_gnt after E0; sel=0; m_addr=0x10; if_valid after E2 with if_rdata=0xDEADBEEF.
REQ-039 Simultaneous if_req and mem_req (read, addr 0x80), fixed priority -> mem served first (sel=1), then fetch; stall held until if_valid.
REQ-040 Same stimulus with MEM_ARB_RR_EN, two back-to-back ties -> grant order mem, if, mem, if.
REQ-041 mem_we=1, addr 0x44, wdata 0x12345678 -> m_we=1 for LATENCY cycles with m_addr=0x44 and m_wdata=0x12345678; mem_valid pulses once; m_we=0 afterward.
REQ-042 rst low one cycle after grant -> no valid pulse; all outputs 0; after release, a pending request is granted normally.
REQ-043 LATENCY=1, continuous if_req -> if_valid every 2nd cycle; never two grants without an intervening valid.
